// File: rtl/uart_wr_sequencer.sv
// Host-side write sequencer for a UART register interface: buffers config and transmit bytes,
// shapes write strobes around held data, then starts the transmitter and paces on its busy flag.
module uart_wr_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ADDR_W        = 2,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned BUSY_TIMEOUT  = 15
) (
    input  logic            i_Clock,
    input  logic            i_reset,
    input  logic            i_cfg_valid,
    input  logic [7:0]      i_cfg_brg,
    output logic            o_cfg_ready,
    input  logic            i_tx_valid,
    input  logic [7:0]      i_tx_data,
    output logic            o_tx_ready,
    input  logic            i_tx_busy,
    output logic [7:0]      o_data,
    output logic            o_brg_we,
    output logic            o_data_we,
    output logic            o_tx_start,
    output logic [ADDR_W:0] o_fifo_count,
    output logic            o_err,
    output logic            o_idle
);

    localparam int unsigned StrobeW  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int unsigned TimeoutW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StStrobe, StHold, StStart, StWaitBusy} state_e;

    state_e              state_q, state_d;
    logic                sel_q, sel_d;  // 1: data register, 0: baud register
    logic [7:0]          data_q, data_d;
    logic                brg_we_q, brg_we_d;
    logic                data_we_q, data_we_d;
    logic [StrobeW-1:0]  strobe_cnt_q, strobe_cnt_d;
    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
    logic                cfg_full_q, cfg_full_d;
    logic [7:0]          cfg_val_q, cfg_val_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;

    logic tx_ready;
    logic push;
    logic cfg_load;
    logic grant_cfg;
    logic grant_data;

    assign tx_ready = (count_q != (ADDR_W + 1)'(FIFO_DEPTH));
    assign push     = i_tx_valid & tx_ready;
    assign cfg_load = i_cfg_valid & ~cfg_full_q;

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            data_q       <= '0;
            brg_we_q     <= 1'b0;
            data_we_q    <= 1'b0;
            strobe_cnt_q <= '0;
            to_cnt_q     <= '0;
            cfg_full_q   <= 1'b0;
            cfg_val_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            brg_we_q     <= brg_we_d;
            data_we_q    <= data_we_d;
            strobe_cnt_q <= strobe_cnt_d;
            to_cnt_q     <= to_cnt_d;
            cfg_full_q   <= cfg_full_d;
            cfg_val_q    <= cfg_val_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        data_d       = data_q;
        strobe_cnt_d = strobe_cnt_q;
        to_cnt_d     = to_cnt_q;
        grant_cfg    = 1'b0;
        grant_data   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!i_tx_busy && cfg_full_q) begin
                    grant_cfg    = 1'b1;
                    data_d       = cfg_val_q;
                    sel_d        = 1'b0;
                    strobe_cnt_d = '0;
                    state_d      = StStrobe;
                end else if (!i_tx_busy && (count_q != '0)) begin
                    grant_data   = 1'b1;
                    data_d       = mem_q[rd_ptr_q];
                    sel_d        = 1'b1;
                    strobe_cnt_d = '0;
                    state_d      = StStrobe;
                end
            end
            StStrobe: begin
                if (strobe_cnt_q == StrobeW'(STROBE_CYCLES - 1)) state_d = StHold;
                else strobe_cnt_d = strobe_cnt_q + 1'b1;
            end
            StHold: state_d = sel_q ? StStart : StIdle;
            StStart: begin
                to_cnt_d = '0;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (i_tx_busy || (to_cnt_q == TimeoutW'(BUSY_TIMEOUT - 1))) state_d = StIdle;
                else to_cnt_d = to_cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Enables are registered so they rise exactly with the latched data.
        brg_we_d  = (state_d == StStrobe) & ~sel_d;
        data_we_d = (state_d == StStrobe) & sel_d;

        cfg_full_d = cfg_load | (cfg_full_q & ~grant_cfg);
        cfg_val_d  = cfg_load ? i_cfg_brg : cfg_val_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_tx_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (grant_data) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, grant_data})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        o_cfg_ready  = ~cfg_full_q;
        o_tx_ready   = tx_ready;
        o_data       = data_q;
        o_brg_we     = brg_we_q;
        o_data_we    = data_we_q;
        o_fifo_count = count_q;
        o_tx_start   = (state_q == StStart);
        o_err        = (state_q == StWaitBusy) & ~i_tx_busy &
                       (to_cnt_q == TimeoutW'(BUSY_TIMEOUT - 1));
        o_idle       = (state_q == StIdle) & (count_q == '0) & ~cfg_full_q;
    end

endmodule

// File: tb/tb_uart_wr_sequencer.sv
// Randomised scoreboard bench for uart_wr_sequencer: accepted requests feed a timestamped model,
// a monitor pops the expected write on every strobe and checks shape, pacing and timeout pulses.
module tb_uart_wr_sequencer;

    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned ADDR_W        = 2;
    localparam int unsigned STROBE_CYCLES = 1;
    localparam int unsigned BUSY_TIMEOUT  = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [7:0]      cfg_brg = 8'h00;
    logic            cfg_ready;
    logic            tx_valid = 1'b0;
    logic [7:0]      tx_data = 8'h00;
    logic            tx_ready;
    logic            busy = 1'b0;
    logic [7:0]      data;
    logic            brg_we;
    logic            data_we;
    logic            tx_start;
    logic [ADDR_W:0] fifo_count;
    logic            err;
    logic            idle;

    uart_wr_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .ADDR_W       (ADDR_W),
        .STROBE_CYCLES(STROBE_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .i_Clock     (clk),
        .i_reset     (rst_n),
        .i_cfg_valid (cfg_valid),
        .i_cfg_brg   (cfg_brg),
        .o_cfg_ready (cfg_ready),
        .i_tx_valid  (tx_valid),
        .i_tx_data   (tx_data),
        .o_tx_ready  (tx_ready),
        .i_tx_busy   (busy),
        .o_data      (data),
        .o_brg_we    (brg_we),
        .o_data_we   (data_we),
        .o_tx_start  (tx_start),
        .o_fifo_count(fifo_count),
        .o_err       (err),
        .o_idle      (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rsp_mode = 0;   // 0 manual, 1 fixed delay, 2 never respond, 3 random
    int rsp_delay = 2;

    // Model: pending requests with the cycle they were accepted in.
    int m_cfg_val[$];
    int m_cfg_cyc[$];
    int m_byte_val[$];
    int m_byte_cyc[$];
    logic [8:0] wlog[$];

    int last_tx_acc = -1;
    int last_cfg_acc = -1;
    int last_rise = -1;
    int last_start = -1;
    int err_gap = -1;
    int n_start = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance recorder and cycle counter.
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                m_byte_val.push_back(int'(tx_data));
                m_byte_cyc.push_back(cyc);
                last_tx_acc = cyc;
            end
            if (cfg_valid && cfg_ready) begin
                m_cfg_val.push_back(int'(cfg_brg));
                m_cfg_cyc.push_back(cyc);
                last_cfg_acc = cyc;
            end
        end
        cyc = cyc + 1;
    end

    // Transmitter stand-in: raises busy some cycles after each start pulse.
    int rd;
    int rh;
    initial forever begin
        @(posedge clk);
        if (rst_n && tx_start && (rsp_mode == 1 || rsp_mode == 3)) begin
            rd = (rsp_mode == 1) ? rsp_delay : $urandom_range(1, 4);
            if (rsp_mode == 3 && $urandom_range(0, 4) == 0) rd = 0;
            if (rd > 0) begin
                repeat (rd - 1) @(posedge clk);
                #1 busy = 1'b1;
                rh = $urandom_range(1, 4);
                repeat (rh) @(posedge clk);
                #1 busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    logic       prev_any = 1'b0;
    logic       any_we;
    logic       cur_is_data = 1'b0;
    logic [7:0] cur_data = 8'h00;
    int strobe_len = 0;
    int exp_start = -1;
    int wait_start = -1;
    int ek;
    int ev;
    logic exp_err;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_any   = 1'b0;
            exp_start  = -1;
            wait_start = -1;
            strobe_len = 0;
        end else begin
            any_we = brg_we | data_we;
            chk("we_exclusive", 32'(brg_we & data_we), 32'd0);
            if (any_we && !prev_any) begin
                ek = 2;
                ev = 0;
                if (m_cfg_val.size() > 0 && m_cfg_cyc[0] <= cyc - 2) begin
                    ek = 0;
                    ev = m_cfg_val.pop_front();
                    void'(m_cfg_cyc.pop_front());
                end else if (m_byte_val.size() > 0 && m_byte_cyc[0] <= cyc - 2) begin
                    ek = 1;
                    ev = m_byte_val.pop_front();
                    void'(m_byte_cyc.pop_front());
                end
                chk("write_kind", 32'(data_we), ek);
                if (ek != 2) chk("write_data", 32'(data), ev);
                wlog.push_back({data_we, data});
                last_rise   = cyc;
                cur_data    = data;
                cur_is_data = data_we;
                strobe_len  = 1;
            end else if (any_we && prev_any) begin
                strobe_len++;
                chk("strobe_data_stable", 32'(data), 32'(cur_data));
                chk("strobe_kind_stable", 32'(data_we), 32'(cur_is_data));
            end else if (!any_we && prev_any) begin
                chk("strobe_width", strobe_len, STROBE_CYCLES);
                chk("hold_data", 32'(data), 32'(cur_data));
                if (cur_is_data) exp_start = cyc + 1;
            end
            prev_any = any_we;

            chk("tx_start", 32'(tx_start), 32'(exp_start == cyc));
            if (exp_start <= cyc) exp_start = -1;
            if (tx_start) begin
                last_start = cyc;
                n_start++;
                wait_start = cyc;
            end

            exp_err = (wait_start >= 0) && (cyc > wait_start) && !busy &&
                      (cyc == wait_start + int'(BUSY_TIMEOUT));
            if (wait_start >= 0 && cyc > wait_start &&
                (busy || cyc == wait_start + int'(BUSY_TIMEOUT))) wait_start = -1;
            chk("err_pulse", 32'(err), 32'(exp_err));
            if (err) begin
                n_err++;
                err_gap = cyc - last_start;
            end
        end
    end

    task automatic wait_idle(input string name);
        int stable = 0;
        int n = 0;
        repeat (2) @(posedge clk);
        while (stable < 6 && n < 3000) begin
            @(negedge clk);
            n++;
            if (idle) stable++;
            else stable = 0;
        end
        chk({"idle_timeout_", name}, 32'(stable >= 6), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] v);
        @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_data = v;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int s0;
        int e0;
        int sz;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_brg_we", 32'(brg_we), 32'd0);
        chk("rst_data_we", 32'(data_we), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;

        // Config write
        rsp_mode = 1;
        rsp_delay = 2;
        n0 = wlog.size();
        s0 = n_start;
        @(posedge clk);
        #1 cfg_valid = 1'b1;
        cfg_brg = 8'h1A;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        wait_idle("cfg");
        chk("cfg_writes", wlog.size() - n0, 1);
        chk("cfg_log", 32'(wlog[wlog.size() - 1]), {23'd0, 1'b0, 8'h1A});
        chk("cfg_latency", last_rise - last_cfg_acc, 2);
        chk("cfg_no_start", n_start - s0, 0);
        chk("cfg_data_held", 32'(data), 32'h1A);

        // Single byte latency
        push_byte(8'h55);
        wait_idle("byte");
        chk("byte_log", 32'(wlog[wlog.size() - 1]), {23'd0, 1'b1, 8'h55});
        chk("byte_we_latency", last_rise - last_tx_acc, 2);
        chk("byte_start_latency", last_start - last_tx_acc, 4);
        chk("byte_count_empty", 32'(fifo_count), 32'd0);

        // FIFO full and ordering
        rsp_mode = 0;
        @(posedge clk);
        #1 busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 tx_valid = 1'b1;
            tx_data = 8'(i + 1);
            if (i == 4) begin
                chk("full_tx_ready", 32'(tx_ready), 32'd0);
                chk("full_count", 32'(fifo_count), 32'd4);
            end
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("full_count_hold", 32'(fifo_count), 32'd4);
        busy = 1'b0;
        rsp_mode = 1;
        wait_idle("full");
        sz = wlog.size();
        for (int i = 0; i < 4; i++)
            chk("full_order", 32'(wlog[sz - 4 + i]), 32'({1'b1, 8'(i + 1)}));
        chk("full_drained", 32'(fifo_count), 32'd0);

        // Config priority over a simultaneously pending byte
        rsp_mode = 0;
        @(posedge clk);
        #1 busy = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b1;
        cfg_brg = 8'h30;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 busy = 1'b0;
        rsp_mode = 1;
        wait_idle("prio");
        sz = wlog.size();
        chk("prio_first_cfg", 32'(wlog[sz - 2]), {23'd0, 1'b0, 8'h30});
        chk("prio_then_data", 32'(wlog[sz - 1]), {23'd0, 1'b1, 8'hA5});

        // Busy timeout, next byte still serviced
        rsp_mode = 2;
        e0 = n_err;
        push_byte(8'h77);
        push_byte(8'h88);
        wait_idle("timeout");
        sz = wlog.size();
        chk("timeout_errs", n_err - e0, 2);
        chk("timeout_gap", err_gap, BUSY_TIMEOUT);
        chk("timeout_first", 32'(wlog[sz - 2]), {23'd0, 1'b1, 8'h77});
        chk("timeout_next", 32'(wlog[sz - 1]), {23'd0, 1'b1, 8'h88});

        // Randomised traffic
        rsp_mode = 3;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 tx_valid = ($urandom_range(0, 2) == 0);
            tx_data = 8'($urandom);
            cfg_valid = ($urandom_range(0, 11) == 0);
            cfg_brg = 8'($urandom);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        cfg_valid = 1'b0;
        wait_idle("random");
        chk("rand_bytes_drained", m_byte_val.size(), 0);
        chk("rand_cfg_drained", m_cfg_val.size(), 0);
        chk("rand_count_empty", 32'(fifo_count), 32'd0);
        repeat (6) @(posedge clk);

        // Reset in the middle of a strobe with bytes queued
        rsp_mode = 0;
        @(posedge clk);
        #1 busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 tx_valid = 1'b1;
            tx_data = 8'(8'h11 + i);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_we && n < 50);
        chk("rst_reached_strobe", 32'(data_we), 32'd1);
        chk("rst_queued", 32'(fifo_count), 32'd3);
        #2 rst_n = 1'b0;
        m_byte_val.delete();
        m_byte_cyc.delete();
        m_cfg_val.delete();
        m_cfg_cyc.delete();
        #1;
        chk("midrst_data_we", 32'(data_we), 32'd0);
        chk("midrst_brg_we", 32'(brg_we), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sz = wlog.size();
        s0 = n_start;
        repeat (20) @(negedge clk);
        chk("postrst_idle", 32'(idle), 32'd1);
        chk("postrst_no_writes", wlog.size() - sz, 0);
        chk("postrst_no_start", n_start - s0, 0);
        chk("postrst_tx_ready", 32'(tx_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_wr_sequencer.md
Name: uart_wr_sequencer

Overview:
- Host-side controller for the UART write interface, which latches brg_we/data_we on the falling edge of the write-enable.
- Accepts baud-divisor configuration requests and transmit bytes from a host.
- Buffers the transmit bytes in a small FIFO and arbitrates between configuration and data, with configuration taking priority.
- Generates correctly shaped write strobes with stable data, then kicks the transmitter and paces on its busy flag.

Parameters:
FIFO_DEPTH, 4, number of transmit byte entries (power of 2, >=2)
ADDR_W, 2, log2(FIFO_DEPTH)
STROBE_CYCLES, 1, cycles the write-enable is held high (>=1)
BUSY_TIMEOUT, 15, max cycles to wait for i_tx_busy after a start pulse (>=1)

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous active-low reset
i_cfg_valid  in  1  host requests a baud-divisor write
i_cfg_brg  in  8  divisor value, sampled when i_cfg_valid & o_cfg_ready
o_cfg_ready  out  1  config holding register empty
i_tx_valid  in  1  host offers a transmit byte
i_tx_data  in  8  byte, sampled when i_tx_valid & o_tx_ready
o_tx_ready  out  1  FIFO not full (combinational)
i_tx_busy  in  1  transmitter is shifting a frame
o_data  out  8  data bus to write interface (registered)
o_brg_we  out  1  baud-register write-enable (registered)
o_data_we  out  1  data-register write-enable (registered)
o_tx_start  out  1  one-cycle pulse: data register updated, start frame
o_fifo_count  out  ADDR_W+1  current FIFO occupancy
o_err  out  1  one-cycle pulse on busy timeout
o_idle  out  1  FSM in IDLE, FIFO empty, no config pending

Behaviour:
- Reset values:
  - o_data=0, o_brg_we=0, o_data_we=0, o_tx_start=0, o_err=0, o_fifo_count=0.
  - Config holder empty, so o_cfg_ready=1.
  - o_tx_ready=1, o_idle=1, FSM in IDLE.
- Reset mid-operation aborts immediately: FIFO and config holder are flushed and all write-enables drop.
- Config holder:
  - Single entry; loads on i_cfg_valid & o_cfg_ready.
  - Clears in the cycle the FSM grants it.
- FIFO:
  - Circular, with pointers wrapping at FIFO_DEPTH.
  - Push on i_tx_valid & o_tx_ready. Push while full is impossible (ready low); any such data is ignored.
  - Pop only on the FSM data grant.
  - Simultaneous push and pop: count is unchanged; the pushed byte lands correctly even when the FIFO is full-minus-pop.
- FSM states: IDLE, STROBE, HOLD, START, WAIT_BUSY.
- IDLE:
  - If a config is pending and i_tx_busy=0: latch the config into o_data, sel=BRG, clear the holder, go to STROBE.
  - Else if the FIFO is non-empty and i_tx_busy=0: pop, latch the byte into o_data, sel=DATA, go to STROBE.
  - Config always wins over a simultaneously pending byte.
- STROBE:
  - o_brg_we or o_data_we (per sel) is 1 for exactly STROBE_CYCLES cycles; o_data is stable.
  - Then go to HOLD.
- HOLD:
  - Write-enable is 0 and o_data is still held for 1 cycle; the write interface captures at the end of this cycle.
  - sel=BRG: go to IDLE. sel=DATA: go to START.
- START: o_tx_start=1 for one cycle, then go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - On i_tx_busy=1: go to IDLE.
  - After BUSY_TIMEOUT cycles without busy: pulse o_err, go to IDLE.
- o_data changes only in IDLE on a grant; it is never changed during STROBE or HOLD.
- Latency (empty FIFO, busy low, STROBE_CYCLES=1):
  - Byte pushed at cycle N.
  - o_data_we high at N+2, low (HOLD) at N+3.
  - o_tx_start at N+4.
- The two write-enables are never high in the same cycle.
- o_idle = (state==IDLE) & FIFO empty & config holder empty.

Test Plan:
- Config write: reset, i_cfg_brg=0x1A for 1 cycle, busy=0 -> o_brg_we high 1 cycle with o_data=0x1A, then low with o_data=0x1A held; o_data_we never high; o_tx_start never pulses; o_idle returns to 1.
- Single byte: push 0x55, i_tx_busy rises 2 cycles after o_tx_start -> o_data_we at N+2, o_tx_start at N+4, o_fifo_count returns to 0.
- FIFO full/order: push 0x01..0x05 back-to-back with busy=1 -> o_tx_ready drops after 4 pushes and 0x05 is rejected; after busy clears, bytes go out 0x01,0x02,0x03,0x04 in order.
- Priority: config 0x30 and byte 0xA5 pending simultaneously, busy=0 -> brg write completes first, then data write of 0xA5.
- Timeout: push 0x77, hold i_tx_busy=0 -> o_err pulses BUSY_TIMEOUT cycles after o_tx_start; the next byte is then serviced.
- Reset mid-STROBE with 3 bytes queued -> o_data_we=0 and o_fifo_count=0 immediately; after release, o_idle=1 and there are no further writes.
